// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, datapath width, reset PC and
// instruction field bounds used by the front end and the main decoder.
package cpu_pkg;

  localparam int unsigned XLEN = 32'd32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned OPCODE_HI = 32'd31;
  localparam int unsigned OPCODE_LO = 32'd26;
  localparam int unsigned FUNCT_HI  = 32'd5;
  localparam int unsigned FUNCT_LO  = 32'd0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter: PC flop, +4 incrementer (wraps modulo 2^N) and redirect
// mux that forces redirect targets onto a word boundary.
module pc_register
  import cpu_pkg::*;
#(
  parameter int unsigned  N        = XLEN,
  parameter logic [N-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [N-1:0] target_i,
  input  logic         inc_i,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] pc_plus4_o,
  output logic [N-1:0] pc_next_o
);

  localparam logic [N-1:0] STEP       = N'(4);
  localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;
  logic [N-1:0] pc_plus4_s;

  // Next-PC selection: redirect beats sequential advance.
  always_comb begin
    pc_plus4_s = pc_q + STEP;
    if (load_i) begin
      pc_d = target_i & ALIGN_MASK;
    end else if (inc_i) begin
      pc_d = pc_plus4_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_s;
  assign pc_next_o  = pc_d;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: request FSM, IF/ID register and a one-entry skid
// buffer that absorbs a word returning while decode is stalled.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned  N        = XLEN,
  parameter logic [N-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         if_valid,
  output logic [N-1:0] if_instr,
  output logic [N-1:0] if_pc_plus4,
  output logic [5:0]   opcode,
  output logic [5:0]   functi
);

  fetch_state_e state_q;
  logic         imem_req_q;
  logic [N-1:0] imem_addr_q;
  logic         if_valid_q;
  logic [N-1:0] if_instr_q;
  logic [N-1:0] if_pc_plus4_q;
  logic         skid_valid_q;
  logic [N-1:0] skid_instr_q;
  logic [N-1:0] skid_pc_plus4_q;

  logic [N-1:0] pc_s;
  logic [N-1:0] pc_plus4_s;
  logic [N-1:0] pc_next_s;
  logic         pc_inc_s;
  logic         ifid_free_s;
  logic         consume_s;

  // Only an ack against our own live request in FETCH advances the PC.
  always_comb begin
    pc_inc_s    = (state_q == ST_FETCH) && imem_req_q && imem_ack;
    consume_s   = if_valid_q && !stall;
    ifid_free_s = !if_valid_q || !stall;
  end

  pc_register #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (redirect),
    .target_i   (redirect_pc),
    .inc_i      (pc_inc_s),
    .pc_o       (pc_s),
    .pc_plus4_o (pc_plus4_s),
    .pc_next_o  (pc_next_s)
  );

  // Fetch FSM with registered request, IF/ID and skid state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_FETCH;
      imem_req_q      <= 1'b0;
      imem_addr_q     <= RESET_PC;
      if_valid_q      <= 1'b0;
      if_instr_q      <= '0;
      if_pc_plus4_q   <= '0;
      skid_valid_q    <= 1'b0;
      skid_instr_q    <= '0;
      skid_pc_plus4_q <= '0;
    end else if (redirect) begin
      // Redirect flushes everything; an unanswered request must still be drained.
      if_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      imem_req_q   <= 1'b1;
      if (imem_req_q && !imem_ack) begin
        state_q <= ST_DRAIN;
      end else begin
        state_q     <= ST_FETCH;
        imem_addr_q <= pc_next_s;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_req_q && imem_ack) begin
            if (ifid_free_s) begin
              if_valid_q    <= 1'b1;
              if_instr_q    <= imem_rdata;
              if_pc_plus4_q <= pc_plus4_s;
              imem_req_q    <= 1'b1;
              imem_addr_q   <= pc_next_s;
            end else begin
              skid_valid_q    <= 1'b1;
              skid_instr_q    <= imem_rdata;
              skid_pc_plus4_q <= pc_plus4_s;
              imem_req_q      <= 1'b0;
              state_q         <= ST_HOLD;
            end
          end else if (!imem_req_q && if_valid_q && stall) begin
            imem_req_q <= 1'b0;
            state_q    <= ST_HOLD;
          end else begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_next_s;
            if (consume_s) begin
              if_valid_q <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            if_valid_q    <= skid_valid_q;
            if_instr_q    <= skid_valid_q ? skid_instr_q : if_instr_q;
            if_pc_plus4_q <= skid_valid_q ? skid_pc_plus4_q : if_pc_plus4_q;
            skid_valid_q  <= 1'b0;
            imem_req_q    <= 1'b1;
            imem_addr_q   <= pc_next_s;
            state_q       <= ST_FETCH;
          end else begin
            imem_req_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          imem_req_q <= 1'b1;
          if (imem_ack) begin
            imem_addr_q <= pc_next_s;
            state_q     <= ST_FETCH;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b0;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign opcode      = if_instr_q[OPCODE_HI:OPCODE_LO];
  assign functi      = if_instr_q[FUNCT_HI:FUNCT_LO];

  logic unused_pc_s;
  assign unused_pc_s = ^pc_s;

endmodule
